// File: rtl/adder_seq_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encoding and a
// constant clog2 helper used to size the chunk index counter.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a single-chunk adder still gets a counter bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/adder_seq_add_chunk.sv
// Combinational CHUNK-bit ripple adder built from single-bit full adders; also
// exposes the carry into its MSB so the top can derive signed overflow.
module addbit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        addbit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/adder_seq.sv
// Multi-cycle adder: adds WIDTH-bit operands plus carry-in CHUNK bits per clock
// behind a start/done handshake, with registered sum, carry-out and overflow.
module adder_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = clog2_min1(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_reg[idx*CHUNK +: CHUNK]),
        .b    (b_reg[idx*CHUNK +: CHUNK]),
        .cin  (carry_reg),
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    // DONE accepts a new start exactly like IDLE so additions can run back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= ci;
                        result    <= '0;
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result[idx*CHUNK +: CHUNK] <= chunk_sum;
                    carry_reg                  <= chunk_cout;
                    if (idx == LAST_IDX) begin
                        carry    <= chunk_cout;
                        overflow <= chunk_cout ^ chunk_cmsb;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: three configurations (32/4, 4/1, 8/8)
// compared against plain-arithmetic sums with directed and random operands.
module tb_adder_seq;

    logic clk = 1'b0;
    logic reset;

    logic        start;
    logic [31:0] a, b;
    logic        ci;
    logic        busy, done, carry, overflow;
    logic [31:0] result;

    logic       s_start, s_ci, s_busy, s_done, s_carry, s_overflow;
    logic [3:0] s_a, s_b, s_result;

    logic       d_start, d_ci, d_busy, d_done, d_carry, d_overflow;
    logic [7:0] d_a, d_b, d_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_seq #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .result(result), .carry(carry), .overflow(overflow)
    );

    adder_seq #(.WIDTH(4), .CHUNK(1)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .a(s_a), .b(s_b), .ci(s_ci),
        .busy(s_busy), .done(s_done), .result(s_result), .carry(s_carry), .overflow(s_overflow)
    );

    adder_seq #(.WIDTH(8), .CHUNK(8)) dut_deg (
        .clk(clk), .reset(reset), .start(d_start), .a(d_a), .b(d_b), .ci(d_ci),
        .busy(d_busy), .done(d_done), .result(d_result), .carry(d_carry), .overflow(d_overflow)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        a = av;
        b = bv;
        ci = cv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One addition on the 32/4 instance; optionally scramble inputs and pulse start during RUN.
    task automatic runMain(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                           input bit disturb);
        logic [32:0] full;
        logic        ov;
        int          edges;
        int          both_high;
        full = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
        ov   = (av[31] == bv[31]) && (full[31] != av[31]);
        applyStimulus(av, bv, cv);
        checkOutput("main_busy_after_accept", {63'd0, busy}, 64'd1);
        edges = 0;
        both_high = 0;
        while (!done && edges < 100) begin
            if (disturb) begin
                a     = $urandom;
                b     = $urandom;
                ci    = 1'($urandom);
                start = 1'($urandom);
            end
            step();
            edges++;
            if (busy && done) both_high++;
        end
        start = 1'b0;
        checkOutput("main_latency", 64'(edges), 64'd8);
        checkOutput("main_busy_done_overlap", 64'(both_high), 64'd0);
        checkOutput("main_result", {32'd0, result}, {32'd0, full[31:0]});
        checkOutput("main_carry", {63'd0, carry}, {63'd0, full[32]});
        checkOutput("main_overflow", {63'd0, overflow}, {63'd0, ov});
        step();
        checkOutput("main_done_single_pulse", {63'd0, done}, 64'd0);
        checkOutput("main_result_hold", {32'd0, result}, {32'd0, full[31:0]});
    endtask

    task automatic runSmall(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        logic [4:0] full;
        logic       ov;
        int         edges;
        int         busy_cycles;
        full = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
        ov   = (av[3] == bv[3]) && (full[3] != av[3]);
        s_a = av;
        s_b = bv;
        s_ci = cv;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        busy_cycles = s_busy ? 1 : 0;
        edges = 0;
        while (!s_done && edges < 50) begin
            step();
            edges++;
            if (s_busy) busy_cycles++;
        end
        checkOutput("small_latency", 64'(edges), 64'd4);
        checkOutput("small_busy_cycles", 64'(busy_cycles), 64'd4);
        checkOutput("small_result", {60'd0, s_result}, {60'd0, full[3:0]});
        checkOutput("small_carry", {63'd0, s_carry}, {63'd0, full[4]});
        checkOutput("small_overflow", {63'd0, s_overflow}, {63'd0, ov});
        step();
    endtask

    task automatic runDeg(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] full;
        logic       ov;
        int         edges;
        full = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        ov   = (av[7] == bv[7]) && (full[7] != av[7]);
        d_a = av;
        d_b = bv;
        d_ci = cv;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        checkOutput("deg_busy_after_accept", {63'd0, d_busy}, 64'd1);
        edges = 0;
        while (!d_done && edges < 50) begin
            step();
            edges++;
        end
        checkOutput("deg_latency", 64'(edges), 64'd1);
        checkOutput("deg_result", {56'd0, d_result}, {56'd0, full[7:0]});
        checkOutput("deg_carry", {63'd0, d_carry}, {63'd0, full[8]});
        checkOutput("deg_overflow", {63'd0, d_overflow}, {63'd0, ov});
        step();
    endtask

    initial begin
        logic [31:0] a1, b1, a2, b2;
        logic [32:0] f1, f2;
        int          edges;
        int          stray_done;

        reset = 1'b1;
        start = 1'b0; a = '0; b = '0; ci = 1'b0;
        s_start = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0;
        d_start = 1'b0; d_a = '0; d_b = '0; d_ci = 1'b0;
        step();
        step();
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_result", {32'd0, result}, 64'd0);
        checkOutput("reset_carry", {63'd0, carry}, 64'd0);
        checkOutput("reset_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("reset_small_result", {60'd0, s_result}, 64'd0);
        reset = 1'b0;
        step();

        // Directed cases from the datasheet
        runSmall(4'd10, 4'd2, 1'b1);
        runMain(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        runMain(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        runMain(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        runMain(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1);

        // Random operands on every configuration
        for (int i = 0; i < 12; i++) runMain($urandom, $urandom, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) runSmall(4'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) runDeg(8'($urandom), 8'($urandom), 1'($urandom));
        runDeg(8'h7F, 8'h00, 1'b1);

        // Start held high through DONE: second addition accepted on the done cycle
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        f1 = {1'b0, a1} + {1'b0, b1};
        f2 = {1'b0, a2} + {1'b0, b2} + 33'd1;
        applyStimulus(a1, b1, 1'b0);
        start = 1'b1;
        a = a2; b = b2; ci = 1'b1;
        edges = 0;
        while (!done && edges < 100) begin
            step();
            edges++;
        end
        checkOutput("b2b_first_latency", 64'(edges), 64'd8);
        checkOutput("b2b_first_result", {32'd0, result}, {32'd0, f1[31:0]});
        checkOutput("b2b_first_carry", {63'd0, carry}, {63'd0, f1[32]});
        step();
        start = 1'b0;
        checkOutput("b2b_second_accepted", {63'd0, busy}, 64'd1);
        edges = 1;
        while (!done && edges < 100) begin
            step();
            edges++;
        end
        checkOutput("b2b_second_spacing", 64'(edges), 64'd9);
        checkOutput("b2b_second_result", {32'd0, result}, {32'd0, f2[31:0]});
        checkOutput("b2b_second_carry", {63'd0, carry}, {63'd0, f2[32]});
        step();

        // Reset in the middle of RUN aborts without a done pulse
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step();
        step();
        step();
        checkOutput("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_done", {63'd0, done}, 64'd0);
        checkOutput("abort_result", {32'd0, result}, 64'd0);
        checkOutput("abort_carry", {63'd0, carry}, 64'd0);
        stray_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) stray_done++;
        end
        checkOutput("abort_no_done", 64'(stray_done), 64'd0);
        runMain(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
